// File: rtl/uart_byte_packer.sv
// Little-endian byte-to-word packer for the UART RX path with flush, one-word output buffer and sticky overrun.
// Optional idle auto-flush is compiled in with UART_PACK_TIMEOUT_EN.
module uart_byte_packer #(
  parameter int MAX_BYTES      = 3,
  parameter int OUT_W          = 32,
  parameter int CNT_W          = $clog2(MAX_BYTES + 1),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int ACC_W = 8 * MAX_BYTES;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_BYTES);

  logic [ACC_W-1:0] acc_q, acc_d, nxt_acc;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, nxt_cnt;
  logic             flush_pend_q, flush_pend_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             overflow_q, overflow_d;

  logic accept, drop, tmo_hit, xfer_req, out_free, xfer;

  assign in_ready  = (acc_cnt_q < FULL_CNT);
  assign accept    = in_valid && in_ready;
  assign drop      = in_valid && !in_ready;
  assign out_free  = !out_valid_q || out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign overflow  = overflow_q;

  // Post-write view of the accumulator: a byte accepted this cycle joins any word transferred this cycle.
  always_comb begin
    nxt_acc = acc_q;
    for (int unsigned k = 0; k < MAX_BYTES; k++) begin
      if (accept && (acc_cnt_q == CNT_W'(k))) begin
        nxt_acc[8*k +: 8] = in_data;
      end
    end
    nxt_cnt = acc_cnt_q + CNT_W'(accept);
  end

  assign xfer_req = (nxt_cnt != '0) &&
                    ((nxt_cnt == FULL_CNT) || flush || flush_pend_q || tmo_hit);
  assign xfer     = xfer_req && out_free;

`ifdef UART_PACK_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMO_MAX = TMR_W'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] timer_q, timer_d;

  // Saturating at the limit keeps the request alive while the output slot is busy.
  assign tmo_hit = (timer_q == TMO_MAX);

  always_comb begin
    timer_d = timer_q;
    if (xfer || accept) begin
      timer_d = '0;
    end else if ((acc_cnt_q != '0) && (timer_q != TMO_MAX)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    acc_d        = nxt_acc;
    acc_cnt_d    = nxt_cnt;
    flush_pend_d = flush_pend_q || (flush && (nxt_cnt != '0));
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    if (xfer) begin
      acc_d        = '0;
      acc_cnt_d    = '0;
      flush_pend_d = 1'b0;
      out_valid_d  = 1'b1;
      out_data_d   = OUT_W'(nxt_acc);
      out_count_d  = nxt_cnt;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_byte_packer.sv
// Bench for uart_byte_packer: directed scenarios then random traffic against a queue-based reference model.
module tb_uart_byte_packer;

  localparam int MB = 3;
  localparam int OW = 32;
  localparam int CW = $clog2(MB + 1);
  localparam int TC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          overflow;

  always #5 clk = ~clk;

  uart_byte_packer #(
    .MAX_BYTES(MB),
    .OUT_W(OW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_count(out_count),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  // Reference model: pending bytes as a queue plus the held output word.
  logic [7:0]    m_acc[$];
  bit            m_pend;
  bit            m_ov;
  logic [OW-1:0] m_od;
  int            m_oc;
  bit            m_ovf;
`ifdef UART_PACK_TIMEOUT_EN
  int            m_tmr;
`endif

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_acc.delete();
    m_pend = 0;
    m_ov   = 0;
    m_od   = '0;
    m_oc   = 0;
    m_ovf  = 0;
`ifdef UART_PACK_TIMEOUT_EN
    m_tmr  = 0;
`endif
  endtask

  task automatic model_step(input bit iv, input logic [7:0] d, input bit fl,
                            input bit ordy, input bit clr);
    int pre, n;
    bit rdy, acc, hit, req, free;
    logic [OW-1:0] w;
    pre = m_acc.size();
    rdy = (pre < MB);
    acc = iv && rdy;
    if (acc) m_acc.push_back(d);
    n = m_acc.size();
    hit = 0;
`ifdef UART_PACK_TIMEOUT_EN
    hit = (m_tmr == TC);
`endif
    req  = (n > 0) && ((n == MB) || fl || m_pend || hit);
    free = !m_ov || ordy;
    if (req && free) begin
      w = '0;
      foreach (m_acc[i]) w = w | (OW'(m_acc[i]) << (8 * i));
      m_od = w;
      m_oc = n;
      m_ov = 1;
      m_acc.delete();
      m_pend = 0;
`ifdef UART_PACK_TIMEOUT_EN
      m_tmr = 0;
`endif
    end else begin
      if (ordy) m_ov = 0;
      if (fl && n > 0) m_pend = 1;
`ifdef UART_PACK_TIMEOUT_EN
      if (acc) m_tmr = 0;
      else if (pre > 0 && m_tmr < TC) m_tmr++;
`endif
    end
    if (iv && !rdy) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
    chk({tag, ".out_data"},  64'(out_data),  64'(m_od));
    chk({tag, ".out_count"}, 64'(out_count), 64'(m_oc));
    chk({tag, ".overflow"},  64'(overflow),  64'(m_ovf));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(m_acc.size() < MB));
  endtask

  // One clock: drive at posedge+1, check in_ready before the edge, then all outputs at next posedge+1.
  task automatic cyc(input bit iv, input logic [7:0] d, input bit fl, input bit ordy,
                     input bit clr, input string tag);
    in_valid  = iv;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    ovf_clr   = clr;
    chk({tag, ".pre_in_ready"}, 64'(in_ready), 64'(m_acc.size() < MB));
    @(posedge clk);
    model_step(iv, d, fl, ordy, clr);
    #1;
    chk_outs(tag);
    in_valid = 0;
    flush    = 0;
    ovf_clr  = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".out_data"},  64'(out_data),  64'd0);
    chk({tag, ".out_count"}, 64'(out_count), 64'd0);
    chk({tag, ".overflow"},  64'(overflow),  64'd0);
    chk({tag, ".in_ready"},  64'(in_ready),  64'd1);
  endtask

  initial begin
    int waited;
    model_reset();
    rst_n = 0;
    #2;
    chk_zero("reset");
    #20;
    @(posedge clk);
    #1;
    rst_n = 1;

    // Full word with consumer ready
    cyc(1, 8'h11, 0, 1, 0, "w1.b0");
    cyc(1, 8'h22, 0, 1, 0, "w1.b1");
    chk("w1.no_early_valid", 64'(out_valid), 64'd0);
    cyc(1, 8'h33, 0, 1, 0, "w1.b2");
    chk("w1.data", 64'(out_data), 64'h0033_2211);
    chk("w1.count", 64'(out_count), 64'd3);
    chk("w1.valid", 64'(out_valid), 64'd1);
    cyc(0, 8'h00, 0, 1, 0, "w1.pop");
    chk("w1.one_cycle", 64'(out_valid), 64'd0);

    // Partial word via flush; then flush on empty
    cyc(1, 8'hAA, 0, 1, 0, "fl.b0");
    cyc(1, 8'hBB, 0, 1, 0, "fl.b1");
    cyc(0, 8'h00, 1, 1, 0, "fl.req");
    chk("fl.data", 64'(out_data), 64'h0000_BBAA);
    chk("fl.count", 64'(out_count), 64'd2);
    cyc(0, 8'h00, 0, 1, 0, "fl.pop");
    cyc(0, 8'h00, 1, 1, 0, "fl.empty");
    cyc(0, 8'h00, 0, 1, 0, "fl.empty2");
    chk("fl.empty_no_word", 64'(out_valid), 64'd0);

    // Backpressure, overflow, back-to-back drain
    for (int i = 1; i <= 6; i++) cyc(1, 8'(i), 0, 0, 0, "bp.fill");
    chk("bp.held", 64'(out_data), 64'h0003_0201);
    chk("bp.in_ready_low", 64'(in_ready), 64'd0);
    cyc(1, 8'h07, 0, 0, 0, "bp.drop");
    chk("bp.overflow", 64'(overflow), 64'd1);
    cyc(0, 8'h00, 0, 1, 0, "bp.pop1");
    chk("bp.word2", 64'(out_data), 64'h0006_0504);
    chk("bp.b2b_valid", 64'(out_valid), 64'd1);
    cyc(0, 8'h00, 0, 1, 1, "bp.pop2");
    chk("bp.ovf_cleared", 64'(overflow), 64'd0);

    // Byte accepted alongside flush
    cyc(1, 8'h77, 0, 1, 0, "fa.b0");
    cyc(1, 8'h5A, 1, 1, 0, "fa.b1");
    chk("fa.data", 64'(out_data), 64'h0000_5A77);
    chk("fa.count", 64'(out_count), 64'd2);
    cyc(0, 8'h00, 0, 1, 0, "fa.pop");

    // Asynchronous reset with a held word and two pending bytes
    for (int i = 0; i < 5; i++) cyc(1, 8'h90 + 8'(i), 0, 0, 0, "ar.fill");
    chk("ar.pre_valid", 64'(out_valid), 64'd1);
    rst_n = 0;
    #1;
    chk_zero("ar.async");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc(1, 8'hC1, 0, 1, 0, "ar.b0");
    cyc(1, 8'hC2, 0, 1, 0, "ar.b1");
    cyc(1, 8'hC3, 0, 1, 0, "ar.b2");
    chk("ar.clean_word", 64'(out_data), 64'h00C3_C2C1);
    cyc(0, 8'h00, 0, 1, 0, "ar.pop");

    // Idle behaviour of a single pending byte
    cyc(1, 8'h42, 0, 1, 0, "to.b0");
`ifdef UART_PACK_TIMEOUT_EN
    waited = 0;
    while (!out_valid && waited < 20) begin
      cyc(0, 8'h00, 0, 1, 0, "to.idle");
      waited++;
    end
    chk("to.latency", 64'(waited), 64'd9);
    chk("to.data", 64'(out_data), 64'h42);
    chk("to.count", 64'(out_count), 64'd1);
    cyc(0, 8'h00, 0, 1, 0, "to.pop");
`else
    waited = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 8'h00, 0, 1, 0, "to.idle");
      if (out_valid) waited++;
    end
    chk("to.no_word_cycles", 64'(waited), 64'd0);
    cyc(0, 8'h00, 1, 1, 0, "to.flush");
    chk("to.flush_data", 64'(out_data), 64'h42);
    cyc(0, 8'h00, 0, 1, 0, "to.pop");
`endif

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(bit'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_byte_packer.md
Name: uart_byte_packer

Overview:
- Parametrised byte-to-word packer for the UART receive path. It accumulates up to MAX_BYTES received bytes, little-endian, into one word and hands the word downstream over a valid/ready interface together with its valid-byte count.
- Differs from the fixed 8-to-24 collector in four ways:
  - width is generic;
  - partial words can be flushed;
  - one-word output buffering allows accumulation to continue while the consumer stalls;
  - overrun is detected.
- Sits between the UART RX byte stream and the host-side FIFO/bus.

Parameters:
- MAX_BYTES, 3, bytes per full word; legal range 1..16.
- OUT_W, 32, output data width; must be >= 8*MAX_BYTES; upper bits are zero-filled.
- CNT_W, $clog2(MAX_BYTES+1), width of the byte-count fields (derived).
- TIMEOUT_CYCLES, 1024, idle cycles before a partial word auto-flushes; used only with UART_PACK_TIMEOUT_EN; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte strobe from the UART RX.
- in_data  in  8  received byte.
- in_ready  out  1  accumulator can take a byte this cycle.
- flush  in  1  single-cycle request to emit the current partial word.
- out_valid  out  1  output word is held and valid.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  OUT_W  packed word; byte k is at bits [8k+7:8k].
- out_count  out  CNT_W  number of valid bytes in out_data (1..MAX_BYTES while out_valid is high).
- overflow  out  1  sticky: a byte was offered while in_ready was low.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (rst_n low, asynchronous) clears everything:
  - accumulator acc = 0, acc_cnt = 0, flush_pend = 0, timer = 0;
  - out_valid = 0, out_data = 0, out_count = 0, overflow = 0.
  - A word held mid-handshake or a partial word is discarded.
- Accept rules:
  - in_ready = (acc_cnt < MAX_BYTES).
  - A byte is accepted when in_valid && in_ready. It is written to acc byte lane acc_cnt.
  - Post-write values: nxt_cnt = acc_cnt + accept; nxt_acc = acc with the byte inserted.
- Flush latch: flush_pend is set by flush while acc_cnt > 0 or while a byte is accepted. It is cleared on transfer.
- Flush with an empty accumulator (nxt_cnt == 0) is ignored: no zero-count word is ever emitted.
- Transfer is requested when nxt_cnt > 0 and any of the following holds:
  - nxt_cnt == MAX_BYTES;
  - flush;
  - flush_pend;
  - timeout hit.
- Transfer fires when the request is present and out_free = (!out_valid || out_ready). On transfer:
  - out_data <= nxt_acc, zero-extended;
  - out_count <= nxt_cnt;
  - out_valid <= 1;
  - acc <= 0, acc_cnt <= 0, flush_pend <= 0, timer <= 0.
  - A byte accepted in the transfer cycle is therefore included in the transferred word.
- Latency: out_valid rises on the clock edge after the completing byte or flush, provided the output slot is free.
- Output handshake:
  - out_data and out_count are held stable while out_valid && !out_ready.
  - On out_ready with no simultaneous transfer, out_valid <= 0.
  - Transfer and pop in the same cycle give back-to-back words with out_valid staying high.
- Backpressure:
  - A full accumulator with the output stalled holds in_ready low until out_ready.
  - Bytes offered in that state are dropped and overflow <= 1.
  - If ovf_clr and a new drop occur in the same cycle, overflow ends at 1 (set wins).
- Lane mapping: bits above 8*out_count in out_data are always 0.

Optional Feature:
- Macro: UART_PACK_TIMEOUT_EN.
- Defined:
  - timer increments each cycle while acc_cnt > 0 and no byte is accepted;
  - timer resets to 0 on any accept or transfer;
  - timer saturates at TIMEOUT_CYCLES;
  - timeout hit = (timer == TIMEOUT_CYCLES), which requests a transfer. The request persists until the output slot is free.
- Not defined: no timer logic; TIMEOUT_CYCLES is ignored; partial words leave only via flush.

Test Plan:
- Reset, then bytes 0x11, 0x22, 0x33 with out_ready=1 -> out_valid one cycle after 0x33, out_data=0x00332211, out_count=3, out_valid for exactly 1 cycle.
- Bytes 0xAA, 0xBB, then flush -> out_data=0x0000BBAA, out_count=2; a flush with an empty accumulator produces no word.
- out_ready=0, send 6 bytes 0x01..0x06 -> first word 0x030201 is held; accumulator fills with 0x060504; in_ready=0. A 7th byte sets overflow=1 and is dropped. Raise out_ready -> words 0x030201 then 0x060504 on consecutive cycles, with out_valid continuously high.
- Byte 0x5A accepted in the same cycle as flush while acc holds 0x77 -> single word 0x5A77, count=2.
- Assert rst_n=0 mid-word (acc_cnt=2, out_valid=1) -> all outputs 0 immediately, without waiting for a clock edge. The next 3 bytes form a clean word.
- With UART_PACK_TIMEOUT_EN and TIMEOUT_CYCLES=8: one byte 0x42, then idle -> out_valid after 8 idle cycles plus 1, out_data=0x42, count=1. Without the macro, no word is emitted after 100 idle cycles.
